// File: rtl/task_10_pkg.sv
// Shared types and widths for the write-key front end.
// Holds operand widths, FSM state encoding and the released key level.
package task_10_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int PCNT_W = 8;

  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/task_10_sync2.sv
// Two-flop synchronizer with a configurable reset value.
// Ports: clk, rst_n (async active-low), d_i raw in, q_o synced out.
module task_10_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/task_10_write_ctrl.sv
// Write-key front end: sync + debounce key, one strobe per press.
// Ports: clk, key0_rst (async low), key1_write raw key, sw_addr,
// sw_value raw switches; wr_key_n strobe, wr_addr, wr_value captured
// operands, key_level_n debounced level, press_cnt accepted presses.
// Macro TASK_10_AUTO_INC_EN: wr_addr from an internal wrapping pointer.
module task_10_write_ctrl
  import task_10_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              key0_rst,
  input  logic              key1_write,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_value,
  output logic              wr_key_n,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_value,
  output logic              key_level_n,
  output logic [PCNT_W-1:0] press_cnt
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              key_s;
  logic [DATA_W-1:0] val_s;
  logic [ADDR_W-1:0] cap_addr;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_key_q, wr_key_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              lvl_q, lvl_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              strobe;

  task_10_sync2 #(
    .WIDTH(1), .RST_VAL(KEY_RELEASED)
  ) u_key_sync (
    .clk(clk), .rst_n(key0_rst),
    .d_i(key1_write), .q_o(key_s)
  );

  task_10_sync2 #(
    .WIDTH(DATA_W), .RST_VAL('0)
  ) u_val_sync (
    .clk(clk), .rst_n(key0_rst),
    .d_i(sw_value), .q_o(val_s)
  );

`ifdef TASK_10_AUTO_INC_EN
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  assign cap_addr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (strobe) ptr_d = ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) ptr_q <= '0;
    else           ptr_q <= ptr_d;
  end
`else
  task_10_sync2 #(
    .WIDTH(ADDR_W), .RST_VAL('0)
  ) u_addr_sync (
    .clk(clk), .rst_n(key0_rst),
    .d_i(sw_addr), .q_o(cap_addr)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strobe  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_s != KEY_RELEASED) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (key_s == KEY_RELEASED) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          state_d = HELD;
          strobe  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s == KEY_RELEASED) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        // A low sample here is release bounce: back to HELD, no strobe.
        if (key_s != KEY_RELEASED) begin
          state_d = HELD;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_key_d = 1'b1;
    addr_d   = addr_q;
    val_d    = val_q;
    pcnt_d   = pcnt_q;
    if (strobe) begin
      wr_key_d = 1'b0;
      addr_d   = cap_addr;
      val_d    = val_s;
      pcnt_d   = pcnt_q + PCNT_W'(1);
    end
    lvl_d = !(state_d == HELD || state_d == RELEASE);
  end

  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_key_q <= 1'b1;
      addr_q   <= '0;
      val_q    <= '0;
      lvl_q    <= 1'b1;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_key_q <= wr_key_d;
      addr_q   <= addr_d;
      val_q    <= val_d;
      lvl_q    <= lvl_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign wr_key_n    = wr_key_q;
  assign wr_addr     = addr_q;
  assign wr_value    = val_q;
  assign key_level_n = lvl_q;
  assign press_cnt   = pcnt_q;

endmodule
